mult_div_unit: RTL

// Iterative 32-bit multiply/divide unit with architectural HI/LO registers; responder to the mult/div

---
 rtl/mult_div_unit.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// Optional macro MULTDIV_EARLY_OUT_EN ends a multiply once the remaining multiplier bits are zero.
module mult_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             mult_op,
   input  logic             signed_op,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t             state;
   state_t             next_state;
   logic [CNT_W-1:0]   count;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic               is_mult;
   logic               neg_result;

   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic [2*WIDTH-1:0] acc_step;
   logic [2*WIDTH-1:0] product;
   logic [WIDTH:0]     rem_shift;
   logic [WIDTH:0]     trial;
   logic               run_last;

   // For divide, acc[WIDTH-1:0] is the remainder, mplier the quotient/dividend, mcand the divisor.
   assign abs_a     = (signed_op && op_a[WIDTH-1]) ? (~op_a + 1'b1) : op_a;
   assign abs_b     = (signed_op && op_b[WIDTH-1]) ? (~op_b + 1'b1) : op_b;
   assign acc_step  = mplier[0] ? (acc + mcand) : acc;
   assign product   = neg_result ? (~acc + 1'b1) : acc;
   assign rem_shift = {acc[WIDTH-1:0], mplier[WIDTH-1]};
   assign trial     = rem_shift - {1'b0, mcand[WIDTH-1:0]};
   assign busy      = (state != IDLE);

`ifdef MULTDIV_EARLY_OUT_EN
   assign run_last = (count == CNT_W'(1)) || (is_mult && ((mplier >> 1) == '0));
`else
   assign run_last = (count == CNT_W'(1));
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Flush dominates start; a start in RUN or FIX restarts the sequence from scratch.
   always_comb begin
      next_state = state;
      if (flush) begin
         next_state = IDLE;
      end else if (start) begin
         next_state = RUN;
      end else begin
         case (state)
            RUN:     if (run_last) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count      <= '0;
         acc        <= '0;
         mcand      <= '0;
         mplier     <= '0;
         is_mult    <= 1'b0;
         neg_result <= 1'b0;
         hi         <= '0;
         lo         <= '0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         if (!flush && state == FIX) begin
            done <= 1'b1;
            if (is_mult) begin
               hi <= product[2*WIDTH-1:WIDTH];
               lo <= product[WIDTH-1:0];
            end else begin
               hi <= acc[WIDTH-1:0];
               lo <= mplier;
            end
         end
         if (!flush && start) begin
            count   <= CNT_W'(WIDTH);
            acc     <= '0;
            is_mult <= mult_op;
            if (mult_op) begin
               mcand      <= {{WIDTH{1'b0}}, abs_a};
               mplier     <= abs_b;
               neg_result <= signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            end else begin
               mcand      <= {{WIDTH{1'b0}}, op_b};
               mplier     <= op_a;
               neg_result <= 1'b0;
            end
         end else if (!flush && state == RUN) begin
            count <= count - CNT_W'(1);
            if (is_mult) begin
               acc    <= acc_step;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
            end else if (!trial[WIDTH]) begin
               acc    <= {{WIDTH{1'b0}}, trial[WIDTH-1:0]};
               mplier <= {mplier[WIDTH-2:0], 1'b1};
            end else begin
               acc    <= {{WIDTH{1'b0}}, rem_shift[WIDTH-1:0]};
               mplier <= {mplier[WIDTH-2:0], 1'b0};
            end
         end
      end
   end

endmodule
